// File: rtl/data_memory.sv
// rtl/data_memory.sv - 64 x 32-bit block data memory with fixed access latency
//
// Purpose: backing store for a data cache. A request is accepted in IDLE,
// held in BUSY for LATENCY edges, and the access completes on entry to DONE.
// Address, data and request type are captured at acceptance, so the cache
// may change or drop them while the access is in flight.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   reset      in   1   synchronous active-high reset
//   read       in   1   block read request, held until busywait seen low
//   write      in   1   block write request, held until busywait seen low
//   address    in   6   block address (64 blocks)
//   writedata  in   32  block to write
//   readdata   out  32  registered read result, held between reads
//   busywait   out  1   combinational stall to the cache
module data_memory #(
  parameter int LATENCY = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [5:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        busywait
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        is_wr_q, is_wr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mem_we;

  // Byte 4A+k of block A lives in bits [8k+7:8k] of mem_q[A].
  logic [31:0] mem_q [64];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    is_wr_d = is_wr_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (read || write) begin
          addr_d  = address;
          wdata_d = writedata;
          // A simultaneous read and write is treated as a write only.
          is_wr_d = write;
          cnt_d   = CNT_INIT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (is_wr_q) begin
            mem_we = 1'b1;
          end else begin
            rdata_d = mem_q[addr_q];
          end
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 6'd0;
      wdata_q <= 32'd0;
      is_wr_q <= 1'b0;
      rdata_q <= 32'd0;
      // Reset wins over an in-flight write: the pending commit is dropped.
      for (int i = 0; i < 64; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
      rdata_q <= rdata_d;
      if (mem_we) begin
        mem_q[addr_q] <= wdata_q;
      end
    end
  end

  // Dropping busywait in DONE lets the cache see valid readdata on the same
  // edge it sees the stall release.
  assign busywait = (read | write) & (state_q != DONE);
  assign readdata = rdata_q;

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - directed self-checking bench for data_memory
module tb_data_memory;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_a, wr_a, rd_b, wr_b;
  logic [5:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata_a, rdata_b;
  logic        bw_a, bw_b;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  data_memory #(.LATENCY(5)) dut_a (
    .clk(clk), .reset(reset), .read(rd_a), .write(wr_a),
    .address(addr), .writedata(wdata), .readdata(rdata_a), .busywait(bw_a)
  );

  data_memory #(.LATENCY(1)) dut_b (
    .clk(clk), .reset(reset), .read(rd_b), .write(wr_b),
    .address(addr), .writedata(wdata), .readdata(rdata_b), .busywait(bw_b)
  );

  typedef struct {
    string       name;
    bit          rd;
    bit          wr;
    logic [5:0]  a;
    logic [31:0] d;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sel_bw(input bit sel);
    return sel ? bw_b : bw_a;
  endfunction

  function automatic logic [31:0] sel_rd(input bit sel);
    return sel ? rdata_b : rdata_a;
  endfunction

  task automatic set_req(input bit sel, input bit rd, input bit wr);
    if (sel) begin
      rd_b = rd; wr_b = wr;
    end else begin
      rd_a = rd; wr_a = wr;
    end
  endtask

  // Count edges until busywait falls; bounded so a stuck DUT cannot hang.
  task automatic wait_low(input bit sel, output int n);
    n = 0;
    while (sel_bw(sel) && n < 40) begin
      tick();
      n++;
    end
  endtask

  // Full request: busywait rise, edges to DONE, readdata in DONE, release.
  task automatic do_req(input bit sel, input string name, input bit rd, input bit wr,
                        input logic [5:0] a, input logic [31:0] d,
                        input int lat, input logic [31:0] exp_rd);
    int n;
    addr = a; wdata = d;
    set_req(sel, rd, wr);
    #1;
    chk({name, " busy_rise"}, 32'(sel_bw(sel)), 32'd1);
    wait_low(sel, n);
    chk({name, " edges_to_done"}, 32'(n), 32'(lat + 1));
    chk({name, " readdata"}, sel_rd(sel), exp_rd);
    set_req(sel, 1'b0, 1'b0);
    #1;
    chk({name, " busy_released"}, 32'(sel_bw(sel)), 32'd0);
    tick();
  endtask

  initial begin
    int n;
    vecs[0] = '{"rd00",      1'b1, 1'b0, 6'h00, 32'h0,        32'h00000000};
    vecs[1] = '{"wr2A",      1'b0, 1'b1, 6'h2A, 32'hDEADBEEF, 32'h00000000};
    vecs[2] = '{"rd2A",      1'b1, 1'b0, 6'h2A, 32'h0,        32'hDEADBEEF};
    vecs[3] = '{"both3F",    1'b1, 1'b1, 6'h3F, 32'hA5A5A5A5, 32'hDEADBEEF};
    vecs[4] = '{"rd3F",      1'b1, 1'b0, 6'h3F, 32'h0,        32'hA5A5A5A5};
    vecs[5] = '{"wr15",      1'b0, 1'b1, 6'h15, 32'h0BADF00D, 32'hA5A5A5A5};
    vecs[6] = '{"rd15",      1'b1, 1'b0, 6'h15, 32'h0,        32'h0BADF00D};
    vecs[7] = '{"rd2A_again",1'b1, 1'b0, 6'h2A, 32'h0,        32'hDEADBEEF};

    reset = 1'b1;
    rd_a = 0; wr_a = 0; rd_b = 0; wr_b = 0;
    addr = '0; wdata = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("reset readdata", rdata_a, 32'h0);
    chk("reset busywait", 32'(bw_a), 32'd0);
    chk("reset readdata L1", rdata_b, 32'h0);

    for (int i = 0; i < 8; i++) begin
      do_req(1'b0, vecs[i].name, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, 5, vecs[i].exp_rd);
    end

    // Address/data change during BUSY are ignored.
    addr = 6'h05; wdata = 32'h11223344; wr_a = 1'b1;
    tick(); tick(); tick();
    addr = 6'h06; wdata = 32'h0;
    wait_low(1'b0, n);
    chk("chg edges_to_done", 32'(n + 3), 32'd6);
    wr_a = 1'b0;
    tick();
    do_req(1'b0, "chg rd05", 1'b1, 1'b0, 6'h05, 32'h0, 5, 32'h11223344);
    do_req(1'b0, "chg rd06", 1'b1, 1'b0, 6'h06, 32'h0, 5, 32'h00000000);

    // Withdrawn write still commits; busywait low while request is low.
    addr = 6'h07; wdata = 32'h00000077; wr_a = 1'b1;
    tick(); tick();
    wr_a = 1'b0;
    #1;
    chk("withdraw busy_low", 32'(bw_a), 32'd0);
    repeat (6) tick();
    do_req(1'b0, "withdraw rd07", 1'b1, 1'b0, 6'h07, 32'h0, 5, 32'h00000077);

    // Back-to-back reads: request held through DONE is re-accepted.
    addr = 6'h2A; rd_a = 1'b1;
    #1;
    wait_low(1'b0, n);
    chk("b2b first edges", 32'(n), 32'd6);
    chk("b2b first data", rdata_a, 32'hDEADBEEF);
    tick();
    chk("b2b idle busy_high", 32'(bw_a), 32'd1);
    addr = 6'h3F;
    wait_low(1'b0, n);
    chk("b2b second edges", 32'(n), 32'd6);
    chk("b2b second data", rdata_a, 32'hA5A5A5A5);
    rd_a = 1'b0;
    tick();

    // Reset during the third BUSY cycle discards the pending write.
    addr = 6'h10; wdata = 32'h12345678; wr_a = 1'b1;
    tick(); tick(); tick();
    reset = 1'b1;
    #1;
    chk("rst busy_prereset", 32'(bw_a), 32'd1);
    tick();
    reset = 1'b0; wr_a = 1'b0;
    #1;
    chk("rst busy_after", 32'(bw_a), 32'd0);
    chk("rst readdata", rdata_a, 32'h0);
    do_req(1'b0, "rst rd10", 1'b1, 1'b0, 6'h10, 32'h0, 5, 32'h00000000);
    do_req(1'b0, "rst rd2A", 1'b1, 1'b0, 6'h2A, 32'h0, 5, 32'h00000000);
    do_req(1'b0, "rst idle_accept", 1'b1, 1'b0, 6'h05, 32'h0, 5, 32'h00000000);

    // LATENCY = 1 instance.
    do_req(1'b1, "L1 wr01", 1'b0, 1'b1, 6'h01, 32'hCAFEF00D, 1, 32'h00000000);
    do_req(1'b1, "L1 rd01", 1'b1, 1'b0, 6'h01, 32'h0, 1, 32'hCAFEF00D);
    do_req(1'b1, "L1 rd02", 1'b1, 1'b0, 6'h02, 32'h0, 1, 32'h00000000);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
